max7219_chain_ctrl: RTL and testbench

MAX7219_CHAIN_CTRL -- requirements
Module: max7219_chain_ctrl

---
 rtl/max7219_pkg.sv | 47 ++++
 rtl/max7219_chain_ctrl_shifter.sv | 99 +++++++++
 rtl/max7219_chain_ctrl.sv | 155 +++++++++++++++
 tb/tb_max7219_chain_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain controller: register map,
// controller state encoding and the hex-to-segment glyph table.
package max7219_pkg;

  localparam logic [7:0] REG_NOP          = 8'h00;
  localparam logic [7:0] REG_DIGIT0       = 8'h01;
  localparam logic [7:0] REG_DECODE_MODE  = 8'h09;
  localparam logic [7:0] REG_INTENSITY    = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN     = 8'h0C;
  localparam logic [7:0] REG_DISPLAY_TEST = 8'h0F;

  localparam logic [3:0] INIT_LAST_IDX = 4'd4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_XFER,
    ST_GAP
  } state_e;

  // Segment bits A..G on bits 6..0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/max7219_chain_ctrl_shifter.sv
// CS/CLK/DIN serialiser: shifts one NUM_DEV*16-bit command word MSB first,
// with spi_clk phase restarting on every start.
module max7219_shifter
  import max7219_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int CLK_DIV = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_DEV*16-1:0]  word,
  output logic                   done,
  output logic                   spi_clk,
  output logic                   spi_dout,
  output logic                   spi_cs
);

  localparam int W  = NUM_DEV * 16;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(W);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(W - 1);

  logic          active_q, active_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          dout_q, dout_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  sr_q, sr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      dout_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
    end else begin
      active_q <= active_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      dout_q   <= dout_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  always_comb begin
    active_d = active_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    dout_d   = dout_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    // High in the cycle whose closing edge drops the last spi_clk and raises CS.
    done = active_q && sclk_q && (div_q == '0) && (bit_q == '0);

    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        cs_d     = 1'b0;
        sclk_d   = 1'b0;
        dout_d   = word[W-1];
        sr_d     = {word[W-2:0], 1'b0};
        div_d    = DIV_LOAD;
        bit_d    = BIT_LOAD;
      end
    end else if (div_q != '0) begin
      div_d = div_q - 1'b1;
    end else begin
      div_d = DIV_LOAD;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        if (bit_q == '0) begin
          active_d = 1'b0;
          cs_d     = 1'b1;
          dout_d   = 1'b0;
        end else begin
          bit_d  = bit_q - 1'b1;
          dout_d = sr_q[W-1];
          sr_d   = {sr_q[W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_clk  = sclk_q;
  assign spi_dout = dout_q;
  assign spi_cs   = cs_q;

endmodule

// File: rtl/max7219_chain_ctrl.sv
// MAX7219 daisy-chain controller: runs the power-up register sequence, then
// pushes accepted frames (intensity + digit registers) to every device.
//
// state   | meaning
// INIT    | launch the first power-up command (held here during reset)
// IDLE    | waiting for a frame, frame_ready high
// XFER    | shifter busy with one command transaction
// GAP     | CS high spacing; launches the next command or returns to IDLE
module max7219_chain_ctrl
  import max7219_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int CLK_DIV    = 25,
  parameter int SCAN_LIMIT = 7,
  parameter int HEX_DECODE = 1
) (
  input  logic                  clk,
  input  logic                  reset_sw,
  input  logic [NUM_DEV*64-1:0] frame_data,
  input  logic [3:0]            frame_intensity,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  spi_clk,
  output logic                  spi_dout,
  output logic                  spi_cs,
  output logic                  busy
);

  localparam int GW = $clog2(2 * CLK_DIV);
  localparam logic [GW-1:0] GAP_LOAD = GW'(2 * CLK_DIV - 1);
  localparam logic [3:0] FRAME_LAST_IDX = 4'(SCAN_LIMIT + 1);

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [3:0]            idx_q, idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [NUM_DEV*64-1:0] data_q, data_d;
  logic [3:0]            inten_q, inten_d;

  logic                  start;
  logic                  done;
  logic                  past_last;
  logic [NUM_DEV*16-1:0] word;
  logic [7:0]            addr, dat, raw;
  logic [2:0]            dig;

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      state_q <= ST_INIT;
      phase_q <= 1'b0;
      idx_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      inten_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      inten_q <= inten_d;
    end
  end

  // Command word for the current phase/index; device NUM_DEV-1 occupies the MSBs.
  always_comb begin
    word = '0;
    addr = 8'h00;
    dat  = 8'h00;
    raw  = 8'h00;
    dig  = 3'(idx_q - 4'd1);
    for (int d = 0; d < NUM_DEV; d++) begin
      raw = data_q[d*64 + int'(dig)*8 +: 8];
      if (!phase_q) begin
        case (idx_q)
          4'd0:    begin addr = REG_DISPLAY_TEST; dat = 8'h00; end
          4'd1:    begin addr = REG_SHUTDOWN;     dat = 8'h01; end
          4'd2:    begin addr = REG_SCAN_LIMIT;   dat = 8'(SCAN_LIMIT); end
          4'd3:    begin addr = REG_DECODE_MODE;  dat = 8'h00; end
          default: begin addr = REG_INTENSITY;    dat = 8'h07; end
        endcase
      end else if (idx_q == 4'd0) begin
        addr = REG_INTENSITY;
        dat  = {4'h0, inten_q};
      end else begin
        addr = REG_DIGIT0 + {5'b0, dig};
        dat  = (HEX_DECODE != 0) ? {raw[7], hex_to_seg(raw[3:0])} : raw;
      end
      word[d*16 +: 16] = {addr, dat};
    end
  end

  assign past_last = phase_q ? (idx_q > FRAME_LAST_IDX) : (idx_q > INIT_LAST_IDX);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    data_d  = data_q;
    inten_d = inten_q;
    start   = 1'b0;
    case (state_q)
      ST_INIT: begin
        start   = 1'b1;
        state_d = ST_XFER;
      end
      ST_IDLE: begin
        if (frame_valid) begin
          data_d  = frame_data;
          inten_d = frame_intensity;
          phase_d = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_XFER: begin
        if (done) begin
          idx_d   = idx_q + 4'd1;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      default: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (past_last) begin
          state_d = ST_IDLE;
        end else begin
          start   = 1'b1;
          state_d = ST_XFER;
        end
      end
    endcase
  end

  assign frame_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  max7219_shifter #(
    .NUM_DEV (NUM_DEV),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (reset_sw),
    .start    (start),
    .word     (word),
    .done     (done),
    .spi_clk  (spi_clk),
    .spi_dout (spi_dout),
    .spi_cs   (spi_cs)
  );

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Directed bench: a 2-device hex-decode instance and a 1-device raw instance,
// with an SPI wire monitor decoding every CS-low transaction.
module tb_max7219_chain_ctrl;

  localparam int CLK_DIV = 2;
  localparam logic [127:0] FRAME_A = {64'h00000000003E0F08, 64'h0000000000010A81};
  localparam logic [127:0] FRAME_B = {64'h0202020202020202, 64'h8888888888888888};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] fd_a;
  logic [3:0]   fi_a;
  logic         fv_a, fr_a, sck_a, sdo_a, scs_a, busy_a;
  logic [63:0]  fd_b;
  logic [3:0]   fi_b;
  logic         fv_b, fr_b, sck_b, sdo_b, scs_b, busy_b;

  max7219_chain_ctrl #(.NUM_DEV(2), .CLK_DIV(CLK_DIV), .SCAN_LIMIT(7), .HEX_DECODE(1)) dut (
    .clk(clk), .reset_sw(rst), .frame_data(fd_a), .frame_intensity(fi_a),
    .frame_valid(fv_a), .frame_ready(fr_a), .spi_clk(sck_a), .spi_dout(sdo_a),
    .spi_cs(scs_a), .busy(busy_a));

  max7219_chain_ctrl #(.NUM_DEV(1), .CLK_DIV(CLK_DIV), .SCAN_LIMIT(7), .HEX_DECODE(0)) dut_raw (
    .clk(clk), .reset_sw(rst), .frame_data(fd_b), .frame_intensity(fi_b),
    .frame_valid(fv_b), .frame_ready(fr_b), .spi_clk(sck_b), .spi_dout(sdo_b),
    .spi_cs(scs_b), .busy(busy_b));

  int checks = 0;
  int failures = 0;

  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];
  int          lq_a[$];
  int          lq_b[$];

  wire [1:0] sck_v = {sck_b, sck_a};
  wire [1:0] sdo_v = {sdo_b, sdo_a};
  wire [1:0] scs_v = {scs_b, scs_a};

  logic        prev_sck[2];
  logic        prev_sdo[2];
  logic        prev_scs[2];
  logic [31:0] sh[2];
  int          nb[2];
  int          lo[2];
  int          hi[2];
  bit          seen[2];
  int          gap_viol = 0;
  int          stab_viol = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_sck[i] = 1'b0; prev_sdo[i] = 1'b0; prev_scs[i] = 1'b1;
        seen[i] = 1'b0; hi[i] = 0; nb[i] = 0; lo[i] = 0; sh[i] = '0;
      end else begin
        if (prev_sck[i] && sck_v[i] && (sdo_v[i] !== prev_sdo[i])) stab_viol++;
        if (!prev_sck[i] && sck_v[i] && (sdo_v[i] !== prev_sdo[i])) stab_viol++;
        if (prev_scs[i] && !scs_v[i]) begin
          if (seen[i] && hi[i] < 2*CLK_DIV) gap_viol++;
          sh[i] = '0; nb[i] = 0; lo[i] = 0;
        end
        if (!scs_v[i]) begin
          lo[i]++;
          hi[i] = 0;
          if (sck_v[i] && !prev_sck[i]) begin
            sh[i] = {sh[i][30:0], sdo_v[i]};
            nb[i]++;
          end
        end else begin
          hi[i]++;
          if (!prev_scs[i]) begin
            seen[i] = 1'b1;
            if (i == 0) begin wq_a.push_back(sh[i]); lq_a.push_back(lo[i]); end
            else        begin wq_b.push_back(sh[i]); lq_b.push_back(lo[i]); end
          end
        end
        prev_sck[i] = sck_v[i];
        prev_sdo[i] = sdo_v[i];
        prev_scs[i] = scs_v[i];
      end
    end
  end

  task automatic clear_queues();
    wq_a.delete(); wq_b.delete(); lq_a.delete(); lq_b.delete();
  endtask

  task automatic wait_ready(input int ch, input int budget, input string tag);
    int n = 0;
    while ((((ch == 0) ? fr_a : fr_b) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout frame_ready low after %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fv_a = 1'b0; fv_b = 1'b0; fd_a = '0; fd_b = '0; fi_a = '0; fi_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (scs_a !== 1'b1)  begin failures++; $display("FAIL reset_cs got=%b exp=1", scs_a); end
    checks++; if (sck_a !== 1'b0)  begin failures++; $display("FAIL reset_clk got=%b exp=0", sck_a); end
    checks++; if (sdo_a !== 1'b0)  begin failures++; $display("FAIL reset_dout got=%b exp=0", sdo_a); end
    checks++; if (fr_a !== 1'b0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", fr_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy_a); end
    checks++; if (scs_b !== 1'b1)  begin failures++; $display("FAIL reset_cs_raw got=%b exp=1", scs_b); end
  endtask

  task automatic check_init(input string tag);
    logic [15:0] iw[5];
    iw = '{16'h0F00, 16'h0C01, 16'h0B07, 16'h0900, 16'h0A07};
    checks++;
    if (wq_a.size() != 5) begin failures++; $display("FAIL %s_count_a got=%0d exp=5", tag, wq_a.size()); end
    checks++;
    if (wq_b.size() != 5) begin failures++; $display("FAIL %s_count_raw got=%0d exp=5", tag, wq_b.size()); end
    for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
      checks++;
      if (wq_a[i] !== {iw[i], iw[i]}) begin
        failures++; $display("FAIL %s_word_a[%0d] got=%h exp=%h", tag, i, wq_a[i], {iw[i], iw[i]});
      end
      checks++;
      if (lq_a[i] != 128) begin failures++; $display("FAIL %s_len_a[%0d] got=%0d exp=128", tag, i, lq_a[i]); end
    end
    for (int i = 0; i < 5 && i < wq_b.size(); i++) begin
      checks++;
      if (wq_b[i] !== {16'h0, iw[i]}) begin
        failures++; $display("FAIL %s_word_raw[%0d] got=%h exp=%h", tag, i, wq_b[i], iw[i]);
      end
      checks++;
      if (lq_b[i] != 64) begin failures++; $display("FAIL %s_len_raw[%0d] got=%0d exp=64", tag, i, lq_b[i]); end
    end
  endtask

  task automatic test_init();
    clear_queues();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (scs_a !== 1'b0) begin failures++; $display("FAIL init_first_cs got=%b exp=0", scs_a); end
    checks++; if (scs_b !== 1'b0) begin failures++; $display("FAIL init_first_cs_raw got=%b exp=0", scs_b); end
    wait_ready(0, 2000, "init_a");
    wait_ready(1, 2000, "init_raw");
    check_init("init");
    checks++; if (fr_a !== 1'b1) begin failures++; $display("FAIL init_ready got=%b exp=1", fr_a); end
  endtask

  task automatic test_hex_frame_handshake();
    logic [31:0] exp_a[9];
    int n;
    exp_a = '{32'h0A030A03, 32'h017F01B0, 32'h02470277, 32'h034F0330, 32'h047E047E,
              32'h057E057E, 32'h067E067E, 32'h077E077E, 32'h087E087E};
    clear_queues();
    @(negedge clk);
    fd_a = FRAME_A; fi_a = 4'h3; fv_a = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (fr_a !== 1'b0)   begin failures++; $display("FAIL accept_ready_drop got=%b exp=0", fr_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL accept_busy got=%b exp=1", busy_a); end
    fd_a = FRAME_B; fi_a = 4'hC;
    n = 0;
    while (busy_a !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL frame_a_timeout busy high after %0d cycles", n); end
    checks++;
    if (wq_a.size() != 9) begin failures++; $display("FAIL frame_a_count got=%0d exp=9", wq_a.size()); end
    for (int i = 0; i < 9 && i < wq_a.size(); i++) begin
      checks++;
      if (wq_a[i] !== exp_a[i]) begin failures++; $display("FAIL frame_a_word[%0d] got=%h exp=%h", i, wq_a[i], exp_a[i]); end
      checks++;
      if (lq_a[i] != 128) begin failures++; $display("FAIL frame_a_len[%0d] got=%0d exp=128", i, lq_a[i]); end
    end
    clear_queues();
    @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL frame_b_accept busy got=%b exp=1", busy_a); end
    fv_a = 1'b0;
    wait_ready(0, 3000, "frame_b");
    checks++;
    if (wq_a.size() != 9) begin failures++; $display("FAIL frame_b_count got=%0d exp=9", wq_a.size()); end
    for (int i = 0; i < 9 && i < wq_a.size(); i++) begin
      logic [31:0] e;
      e = (i == 0) ? 32'h0A0C0A0C : {8'(i), 8'h6D, 8'(i), 8'hFF};
      checks++;
      if (wq_a[i] !== e) begin failures++; $display("FAIL frame_b_word[%0d] got=%h exp=%h", i, wq_a[i], e); end
    end
  endtask

  task automatic test_raw();
    logic [15:0] exp_b[9];
    exp_b = '{16'h0A05, 16'h015A, 16'h0281, 16'h0300, 16'h04FF,
              16'h053E, 16'h0612, 16'h07A7, 16'h08C4};
    clear_queues();
    @(negedge clk);
    fd_b = 64'hC4A7123EFF00815A; fi_b = 4'h5; fv_b = 1'b1;
    @(posedge clk);
    #1 fv_b = 1'b0;
    wait_ready(1, 2000, "raw");
    checks++;
    if (wq_b.size() != 9) begin failures++; $display("FAIL raw_count got=%0d exp=9", wq_b.size()); end
    for (int i = 0; i < 9 && i < wq_b.size(); i++) begin
      checks++;
      if (wq_b[i] !== {16'h0, exp_b[i]}) begin failures++; $display("FAIL raw_word[%0d] got=%h exp=%h", i, wq_b[i], exp_b[i]); end
      checks++;
      if (lq_b[i] != 64) begin failures++; $display("FAIL raw_len[%0d] got=%0d exp=64", i, lq_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_queues();
    @(negedge clk);
    fd_a = FRAME_A; fi_a = 4'h1; fv_a = 1'b1;
    @(posedge clk);
    #1 fv_a = 1'b0;
    n = 0;
    while (!(wq_a.size() >= 1 && scs_a === 1'b0 && nb[0] == 10) && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin failures++; $display("FAIL midreset_timeout bit 10 not reached in %0d cycles", n); end
    #1 rst = 1'b1;
    #1;
    checks++; if (scs_a !== 1'b1)  begin failures++; $display("FAIL midreset_cs got=%b exp=1", scs_a); end
    checks++; if (sck_a !== 1'b0)  begin failures++; $display("FAIL midreset_clk got=%b exp=0", sck_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midreset_busy got=%b exp=1", busy_a); end
    repeat (2) @(negedge clk);
    clear_queues();
    #1 rst = 1'b0;
    wait_ready(0, 2000, "midreset_a");
    wait_ready(1, 2000, "midreset_raw");
    check_init("midreset");
    repeat (20) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midreset_discard busy got=%b exp=0", busy_a); end
    checks++; if (wq_a.size() != 5) begin failures++; $display("FAIL midreset_extra_txn got=%0d exp=5", wq_a.size()); end
  endtask

  task automatic test_protocol();
    checks++;
    if (gap_viol != 0) begin failures++; $display("FAIL cs_gap short gaps=%0d exp=0", gap_viol); end
    checks++;
    if (stab_viol != 0) begin failures++; $display("FAIL dout_stable changes=%0d exp=0", stab_viol); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_hex_frame_handshake();
    test_raw();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
